hazard_ctrl: RTL

Parametrised successor to the pipeline hazard unit for the 5-stage RV32 core.
- Keeps combinational operand forwarding.
- Adds sequenced stall control for:
  - multi-cycle load-use bubbles,
  - a multi-cycle multiply/divide unit in E,
  - data-memory wait states in M.
- Adds saturating performance counters.
- Sits between the controller and the datapath; drives all per-stage stall and flush enables.

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/hazard_fwd_sel.sv | 34 +++
 rtl/hazard_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Encodings shared by the RV32 pipeline control path: result sources,
// forward selects, next-PC select and the hazard sequencer states.
package pipe_pkg;

  typedef enum logic [1:0] {
    RS_ALU  = 2'b00,
    RS_LOAD = 2'b01,
    RS_IMM  = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    FW_RF   = 2'b00,
    FW_W    = 2'b01,
    FW_MIMM = 2'b10,
    FW_MALU = 2'b11
  } fwd_sel_e;

  localparam logic [1:0] PC4 = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_BUB,
    MUL_BUSY,
    MEM_WAIT
  } hazard_state_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Operand forward select for one E-stage source register. A load sitting
// in M has no data yet, so it falls back to the register file.
module hazard_fwd_sel
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] m_rd,
  input  logic [REG_AW-1:0] w_rd,
  input  logic              m_reg_write,
  input  logic              w_reg_write,
  input  logic [1:0]        m_result_src,
  output logic [1:0]        fwd_src
);

  always_comb begin
    fwd_src = FW_RF;
    if (rs == '0) begin
      fwd_src = FW_RF;
    end else if (m_reg_write && (rs == m_rd)) begin
      if (m_result_src == RS_ALU) begin
        fwd_src = FW_MALU;
      end else if (m_result_src == RS_IMM) begin
        fwd_src = FW_MIMM;
      end else begin
        fwd_src = FW_RF;
      end
    end else if (w_reg_write && (rs == w_rd)) begin
      fwd_src = FW_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit for the 5-stage RV32 core: operand forwarding,
// sequenced stall/flush control and saturating performance counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int          REG_AW          = 5,
  parameter int unsigned LOAD_USE_CYCLES = 1,
  parameter int          CNT_W           = 32
) (
  input  logic              clk,
  input  logic              reset_x,
  input  logic [REG_AW-1:0] Di_rs1,
  input  logic [REG_AW-1:0] Di_rs2,
  input  logic [REG_AW-1:0] Ei_rs1,
  input  logic [REG_AW-1:0] Ei_rs2,
  input  logic [REG_AW-1:0] Ei_rd,
  input  logic [REG_AW-1:0] Mi_rd,
  input  logic [REG_AW-1:0] Wi_rd,
  input  logic [1:0]        Ei_PCSrc,
  input  logic [1:0]        Ei_resultSrc,
  input  logic [1:0]        Mi_resultSrc,
  input  logic              Mi_regWrite,
  input  logic              Wi_regWrite,
  input  logic              Ei_mulStart,
  input  logic              Ei_mulDone,
  input  logic              Mi_memReq,
  input  logic              Mi_memReady,
  output logic [1:0]        Eo_forwardIn1Src,
  output logic [1:0]        Eo_forwardIn2Src,
  output logic              Fo_stall,
  output logic              Do_stall,
  output logic              Eo_stall,
  output logic              Mo_stall,
  output logic              Do_flush,
  output logic              Eo_flush,
  output logic              Wo_flush,
  output logic [CNT_W-1:0]  Oo_stallCycles,
  output logic [CNT_W-1:0]  Oo_flushCount
);

  hazard_state_e state, state_nxt, ret_state, ret_nxt, eff_state;
  logic [2:0] bub_cnt, bub_nxt;
  logic mem_wait, lw_hit, redirect, mul_stall;
  logic f_stall, d_stall, e_stall, m_stall, d_flush, e_flush, w_flush;

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd1 (
    .rs           (Ei_rs1),
    .m_rd         (Mi_rd),
    .w_rd         (Wi_rd),
    .m_reg_write  (Mi_regWrite),
    .w_reg_write  (Wi_regWrite),
    .m_result_src (Mi_resultSrc),
    .fwd_src      (Eo_forwardIn1Src)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd2 (
    .rs           (Ei_rs2),
    .m_rd         (Mi_rd),
    .w_rd         (Wi_rd),
    .m_reg_write  (Mi_regWrite),
    .w_reg_write  (Wi_regWrite),
    .m_result_src (Mi_resultSrc),
    .fwd_src      (Eo_forwardIn2Src)
  );

  assign mem_wait = Mi_memReq & ~Mi_memReady;
  assign lw_hit   = (Ei_resultSrc == RS_LOAD) && (Ei_rd != '0) &&
                    ((Di_rs1 == Ei_rd) || (Di_rs2 == Ei_rd));
  assign redirect = (Ei_PCSrc != PC4);

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state     <= IDLE;
      ret_state <= IDLE;
      bub_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_nxt;
      bub_cnt   <= bub_nxt;
    end
  end

  // MEM_WAIT only freezes the pipe; once memory completes, behaviour is
  // that of the state it interrupted, so decode from the effective state.
  always_comb begin
    eff_state = (state == MEM_WAIT) ? ret_state : state;
    state_nxt = eff_state;
    ret_nxt   = ret_state;
    bub_nxt   = bub_cnt;
    mul_stall = 1'b0;
    f_stall   = 1'b0;
    d_stall   = 1'b0;
    e_stall   = 1'b0;
    m_stall   = 1'b0;
    d_flush   = 1'b0;
    e_flush   = 1'b0;
    w_flush   = 1'b0;

    if (mem_wait) begin
      f_stall   = 1'b1;
      d_stall   = 1'b1;
      e_stall   = 1'b1;
      m_stall   = 1'b1;
      w_flush   = 1'b1;
      state_nxt = MEM_WAIT;
      if (state != MEM_WAIT) ret_nxt = state;
    end else begin
      if (eff_state == MUL_BUSY) begin
        if (Ei_mulDone) state_nxt = IDLE;
        else            mul_stall = 1'b1;
      end else if ((eff_state == IDLE) && Ei_mulStart && !Ei_mulDone) begin
        mul_stall = 1'b1;
        state_nxt = MUL_BUSY;
      end

      if (mul_stall) begin
        f_stall = 1'b1;
        d_stall = 1'b1;
        e_stall = 1'b1;
      end else if (redirect) begin
        d_flush   = 1'b1;
        e_flush   = 1'b1;
        state_nxt = IDLE;
        bub_nxt   = '0;
      end else if (eff_state == LOAD_BUB) begin
        f_stall = 1'b1;
        d_stall = 1'b1;
        e_flush = 1'b1;
        bub_nxt = bub_cnt - 3'd1;
        if (bub_cnt <= 3'd1) begin
          state_nxt = IDLE;
          bub_nxt   = '0;
        end
      end else if ((eff_state == IDLE) && lw_hit) begin
        f_stall = 1'b1;
        d_stall = 1'b1;
        e_flush = 1'b1;
        if (LOAD_USE_CYCLES > 1) begin
          state_nxt = LOAD_BUB;
          bub_nxt   = 3'(LOAD_USE_CYCLES - 1);
        end
      end
    end
  end

  assign Fo_stall = reset_x & f_stall;
  assign Do_stall = reset_x & d_stall;
  assign Eo_stall = reset_x & e_stall;
  assign Mo_stall = reset_x & m_stall;
  assign Do_flush = reset_x & d_flush;
  assign Eo_flush = reset_x & e_flush;
  assign Wo_flush = reset_x & w_flush;

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      Oo_stallCycles <= '0;
      Oo_flushCount  <= '0;
    end else begin
      if (Fo_stall && !(&Oo_stallCycles)) Oo_stallCycles <= Oo_stallCycles + CNT_W'(1);
      if (Do_flush && !(&Oo_flushCount))  Oo_flushCount  <= Oo_flushCount + CNT_W'(1);
    end
  end

endmodule
